// File: rtl/ssb_pkg.sv
// Shared types for the system-bus arbiter: host and slave identifiers and the
// outstanding-transaction record kept in the response-ordering FIFO.
package ssb_pkg;

  typedef enum logic [1:0] {
    HOST_DBG   = 2'd0,
    HOST_INSTR = 2'd1,
    HOST_DATA  = 2'd2
  } host_id_e;

  typedef enum logic [1:0] {
    DEV_SRAM  = 2'd0,
    DEV_DEBUG = 2'd1,
    DEV_AXI   = 2'd2,
    DEV_NONE  = 2'd3
  } dev_e;

  typedef struct packed {
    host_id_e host;
    dev_e     dev;
  } outst_t;

  localparam int OUTST_W = $bits(outst_t);

  // Unmapped accesses have no slave, so they select no slave lane.
  function automatic logic [2:0] dev_onehot(input dev_e d);
    dev_onehot = (d == DEV_NONE) ? 3'b000 : (3'b001 << d);
  endfunction

  function automatic logic [2:0] host_onehot(input host_id_e h);
    host_onehot = 3'b001 << h;
  endfunction

endpackage

// File: rtl/ssb_outst_fifo.sv
// In-order record of issued transactions ({host, slave}); the head entry tells
// the arbiter which slave response to expect next and which host receives it.
module ssb_outst_fifo
  import ssb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [OUTST_W-1:0] i_data,
  input  logic               i_pop,
  output logic [OUTST_W-1:0] o_head,
  output logic               o_empty,
  output logic               o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [OUTST_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic [AW:0]        w_count_nxt;
  logic               r_empty;
  logic               r_full;
  logic               w_push;
  logic               w_pop;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH[AW:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/ssb_arbiter.sv
// Shared system bus arbiter: picks one of three hosts, decodes its address to a
// slave, keeps responses in issue order and routes them back to their hosts.
module ssb_arbiter
  import ssb_pkg::*;
#(
  parameter logic [31:0] MEM_START   = 32'h0000_0000,
  parameter logic [31:0] MEM_MASK    = 32'h0001_FFFF,
  parameter logic [31:0] DEBUG_START = 32'h1A11_0000,
  parameter logic [31:0] DEBUG_MASK  = 32'h0000_FFFF,
  parameter logic [31:0] AXI_START   = 32'h0002_0000,
  parameter logic [31:0] AXI_MASK    = 32'h0000_7FFF,
  parameter int          MAX_OUTST   = 4,
  parameter int          STARVE_LIM  = 8
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic [2:0]  h_req_i,
  input  logic [95:0] h_addr_i,
  input  logic [2:0]  h_we_i,
  input  logic [11:0] h_be_i,
  input  logic [95:0] h_wdata_i,
  output logic [2:0]  h_gnt_o,
  output logic [2:0]  h_rvalid_o,
  output logic [2:0]  h_err_o,
  output logic [31:0] h_rdata_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  output logic [2:0]  s_req_o,
  input  logic [2:0]  s_gnt_i,
  input  logic [2:0]  s_rvalid_i,
  input  logic [95:0] s_rdata_i
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0]      r_starve_cnt;
  dev_e               r_cur_dev;
  logic               w_starved;
  logic               w_any_req;
  host_id_e           w_winner;
  logic [31:0]        w_addr;
  logic               w_we;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  dev_e               w_dev;
  logic               w_issue_ok;
  logic               w_grant;
  logic [OUTST_W-1:0] w_head_raw;
  outst_t             w_head;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [2:0]         w_head_sel;
  logic               w_pop;

  function automatic dev_e decode(input logic [31:0] a);
    dev_e d;
    d = DEV_NONE;
    if ((a & ~MEM_MASK) == MEM_START)          d = DEV_SRAM;
    else if ((a & ~DEBUG_MASK) == DEBUG_START) d = DEV_DEBUG;
    else if ((a & ~AXI_MASK) == AXI_START)     d = DEV_AXI;
    return d;
  endfunction

  assign w_starved = (r_starve_cnt == SW'(STARVE_LIM));
  // The bus is dark while reset is held, even with requests pending.
  assign w_any_req = rst_sys_n & (|h_req_i);

  always_comb begin
    w_winner = HOST_DBG;
    if (w_starved && h_req_i[2]) w_winner = HOST_DATA;
    else if (h_req_i[0])         w_winner = HOST_DBG;
    else if (h_req_i[1])         w_winner = HOST_INSTR;
    else if (h_req_i[2])         w_winner = HOST_DATA;
  end

  always_comb begin
    w_addr  = h_addr_i[31:0];
    w_we    = h_we_i[0];
    w_be    = h_be_i[3:0];
    w_wdata = h_wdata_i[31:0];
    case (w_winner)
      HOST_INSTR: begin
        w_addr  = h_addr_i[63:32];
        w_we    = h_we_i[1];
        w_be    = h_be_i[7:4];
        w_wdata = h_wdata_i[63:32];
      end
      HOST_DATA: begin
        w_addr  = h_addr_i[95:64];
        w_we    = h_we_i[2];
        w_be    = h_be_i[11:8];
        w_wdata = h_wdata_i[95:64];
      end
      default: ;
    endcase
  end

  assign w_dev = decode(w_addr);

  // Only one slave may have transactions in flight, so responses stay ordered.
  assign w_issue_ok = w_any_req & ~w_fifo_full & (w_fifo_empty | (w_dev == r_cur_dev));
  assign s_req_o    = w_issue_ok ? dev_onehot(w_dev) : 3'b000;
  assign w_grant    = w_issue_ok & ((w_dev == DEV_NONE) | (|(s_req_o & s_gnt_i)));
  assign h_gnt_o    = w_grant ? host_onehot(w_winner) : 3'b000;

  assign s_addr_o  = w_any_req ? w_addr  : 32'h0;
  assign s_we_o    = w_any_req & w_we;
  assign s_be_o    = w_any_req ? w_be    : 4'h0;
  assign s_wdata_o = w_any_req ? w_wdata : 32'h0;

  assign w_head     = outst_t'(w_head_raw);
  assign w_head_sel = w_fifo_empty ? 3'b000 : dev_onehot(w_head.dev);
  assign w_pop      = ~w_fifo_empty &
                      ((w_head.dev == DEV_NONE) | (|(s_rvalid_i & w_head_sel)));

  assign h_rvalid_o = w_pop ? host_onehot(w_head.host) : 3'b000;
  assign h_err_o    = (w_pop && (w_head.dev == DEV_NONE)) ? host_onehot(w_head.host) : 3'b000;

  always_comb begin
    h_rdata_o = 32'h0;
    if (w_pop) begin
      case (w_head.dev)
        DEV_SRAM:  h_rdata_o = s_rdata_i[31:0];
        DEV_DEBUG: h_rdata_o = s_rdata_i[63:32];
        DEV_AXI:   h_rdata_o = s_rdata_i[95:64];
        default:   h_rdata_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_starve_cnt <= '0;
      r_cur_dev    <= DEV_NONE;
    end else begin
      if (w_grant) r_cur_dev <= w_dev;
      if (h_req_i[2] && !h_gnt_o[2]) begin
        if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  ssb_outst_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_outst_fifo (
    .clk     (clk_sys),
    .rst_n   (rst_sys_n),
    .i_push  (w_grant),
    .i_data  ({w_winner, w_dev}),
    .i_pop   (w_pop),
    .o_head  (w_head_raw),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // A response from any slave other than the head's is a protocol error by the slave.
  a_rvalid_from_head : assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    !w_fifo_empty |-> ((s_rvalid_i & ~w_head_sel) == 3'b000));

endmodule

// File: tb/tb_ssb_arbiter.sv
// Bench for ssb_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a queue-based model of arbitration, ordering and routing.
module tb_ssb_arbiter;

  localparam logic [31:0] MEM_START   = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK    = 32'h0001_FFFF;
  localparam logic [31:0] DEBUG_START = 32'h1A11_0000;
  localparam logic [31:0] DEBUG_MASK  = 32'h0000_FFFF;
  localparam logic [31:0] AXI_START   = 32'h0002_0000;
  localparam logic [31:0] AXI_MASK    = 32'h0000_7FFF;
  localparam int          MAX_OUTST   = 4;
  localparam int          STARVE_LIM  = 8;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic [2:0]  h_req_i;
  logic [95:0] h_addr_i;
  logic [2:0]  h_we_i;
  logic [11:0] h_be_i;
  logic [95:0] h_wdata_i;
  logic [2:0]  h_gnt_o;
  logic [2:0]  h_rvalid_o;
  logic [2:0]  h_err_o;
  logic [31:0] h_rdata_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic [2:0]  s_req_o;
  logic [2:0]  s_gnt_i;
  logic [2:0]  s_rvalid_i;
  logic [95:0] s_rdata_i;

  always #5 clk_sys = ~clk_sys;

  ssb_arbiter #(
    .MEM_START(MEM_START), .MEM_MASK(MEM_MASK), .DEBUG_START(DEBUG_START),
    .DEBUG_MASK(DEBUG_MASK), .AXI_START(AXI_START), .AXI_MASK(AXI_MASK),
    .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .h_req_i(h_req_i), .h_addr_i(h_addr_i),
    .h_we_i(h_we_i), .h_be_i(h_be_i), .h_wdata_i(h_wdata_i), .h_gnt_o(h_gnt_o),
    .h_rvalid_o(h_rvalid_o), .h_err_o(h_err_o), .h_rdata_o(h_rdata_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  // Reference model: list of in-flight transactions and a count of denied cycles.
  typedef struct {
    int host;
    int dev;
  } ent_t;

  ent_t        q[$];
  int          mstarve;
  int          total = 0;
  int          bad   = 0;
  logic [2:0]  exp_gnt, exp_sreq, exp_rv, exp_err;
  logic [31:0] exp_rdata, exp_saddr, exp_swd;
  logic        exp_swe;
  logic [3:0]  exp_sbe;
  logic        m_grant, m_pop;
  int          m_w, m_d;
  logic [31:0] rd [3];

  function automatic int decode(input logic [31:0] a);
    if ((a & ~MEM_MASK) == MEM_START)     return 0;
    if ((a & ~DEBUG_MASK) == DEBUG_START) return 1;
    if ((a & ~AXI_MASK) == AXI_START)     return 2;
    return 3;
  endfunction

  function automatic logic [112:0] obs_v();
    return {h_gnt_o, s_req_o, h_rvalid_o, h_err_o, h_rdata_o, s_addr_o, s_we_o, s_be_o, s_wdata_o};
  endfunction

  function automatic logic [112:0] exp_v();
    return {exp_gnt, exp_sreq, exp_rv, exp_err, exp_rdata, exp_saddr, exp_swe, exp_sbe, exp_swd};
  endfunction

  function automatic logic [31:0] rand_addr(input int region);
    case (region)
      0:       return MEM_START   | ($urandom & MEM_MASK & 32'hFFFF_FFFC);
      1:       return DEBUG_START | ($urandom & DEBUG_MASK & 32'hFFFF_FFFC);
      2:       return AXI_START   | ($urandom & AXI_MASK & 32'hFFFF_FFFC);
      default: return 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
    endcase
  endfunction

  task automatic set_host(input int h, input logic [31:0] a, input logic we);
    h_addr_i[h*32 +: 32]  = a;
    h_we_i[h]             = we;
    h_be_i[h*4 +: 4]      = 4'($urandom);
    h_wdata_i[h*32 +: 32] = $urandom;
  endtask

  // Expected outputs for the present inputs and model state.
  task automatic model_eval();
    m_w = -1;
    if (h_req_i[2] && mstarve >= STARVE_LIM) m_w = 2;
    else for (int h = 2; h >= 0; h--) if (h_req_i[h]) m_w = h;
    exp_gnt = 0; exp_sreq = 0; exp_saddr = 0; exp_swe = 0; exp_sbe = 0; exp_swd = 0;
    m_grant = 0; m_d = 3;
    if (m_w >= 0) begin
      exp_saddr = h_addr_i[m_w*32 +: 32];
      exp_swe   = h_we_i[m_w];
      exp_sbe   = h_be_i[m_w*4 +: 4];
      exp_swd   = h_wdata_i[m_w*32 +: 32];
      m_d       = decode(exp_saddr);
      if (q.size() < MAX_OUTST && (q.size() == 0 || q[$].dev == m_d)) begin
        if (m_d != 3) exp_sreq[m_d] = 1'b1;
        m_grant = (m_d == 3) || s_gnt_i[m_d];
        if (m_grant) exp_gnt[m_w] = 1'b1;
      end
    end
    exp_rv = 0; exp_err = 0; exp_rdata = 0; m_pop = 0;
    if (q.size() > 0) begin
      m_pop = (q[0].dev == 3) || s_rvalid_i[q[0].dev];
      if (m_pop) begin
        exp_rv[q[0].host] = 1'b1;
        if (q[0].dev == 3) exp_err[q[0].host] = 1'b1;
        else exp_rdata = rd[q[0].dev];
      end
    end
    if (!rst_sys_n) begin
      exp_gnt = 0; exp_sreq = 0; exp_rv = 0; exp_err = 0; exp_rdata = 0;
      exp_saddr = 0; exp_swe = 0; exp_sbe = 0; exp_swd = 0; m_grant = 0; m_pop = 0;
    end
  endtask

  // Commit the model, cross the clock edge, then play SRAM/debug slaves.
  task automatic adv();
    logic        sp, dp;
    logic [31:0] sa;
    sp = m_grant && (m_d == 0);
    dp = m_grant && (m_d == 1);
    sa = exp_saddr;
    if (rst_sys_n) begin
      if (m_pop) void'(q.pop_front());
      if (m_grant) q.push_back('{m_w, m_d});
      if (h_req_i[2] && !(m_grant && m_w == 2)) mstarve = (mstarve < STARVE_LIM) ? mstarve + 1 : mstarve;
      else mstarve = 0;
    end
    @(posedge clk_sys);
    #1;
    rd[0] = sp ? (sa ^ 32'h5A5A_0000) : $urandom;
    rd[1] = dp ? ~sa : $urandom;
    rd[2] = $urandom;
    s_rdata_i  = {rd[2], rd[1], rd[0]};
    s_rvalid_i = {1'b0, dp, sp};
  endtask

  task automatic drive_axi_rvalid();
    s_rvalid_i[2]    = 1'b1;
    rd[2]            = $urandom;
    s_rdata_i[95:64] = rd[2];
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    q.delete();
    mstarve = 0;
    for (int h = 0; h < 3; h++) set_host(h, rand_addr(0), 1'b1);
    h_req_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d got=%h want=0", i, obs_v());
      end
      adv();
    end
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    model_eval();
    total++;
    if (h_gnt_o !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_gnt got=%b want=001", h_gnt_o);
    end
    adv();
    h_req_i = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL reset_after cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      adv();
    end
  endtask

  task automatic test_sram_b2b();
    set_host(1, 32'h0000_0100, 1'b0);
    h_req_i = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) h_req_i = 3'b000;
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL sram_b2b cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      if (i < 4) begin
        total++;
        if (h_gnt_o !== 3'b010) begin
          bad++;
          $display("FAIL sram_b2b_gnt cyc%0d got=%b want=010", i, h_gnt_o);
        end
      end
      if (i >= 1 && i <= 4) begin
        total++;
        if (h_rvalid_o !== 3'b010 || h_rdata_o !== 32'h5A5A_0100) begin
          bad++;
          $display("FAIL sram_b2b_rsp cyc%0d got=%b/%h want=010/5a5a0100", i, h_rvalid_o, h_rdata_o);
        end
      end
      adv();
    end
  endtask

  task automatic test_axi_block();
    int first1;
    first1 = -1;
    set_host(2, 32'h0002_0010, 1'b1);
    h_req_i    = 3'b100;
    s_gnt_i[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) s_gnt_i[2] = 1'b1;
      if (i == 4) begin
        h_req_i    = 3'b010;
        set_host(1, 32'h0000_0100, 1'b0);
        s_gnt_i[2] = 1'b0;
      end
      if (i == 6) drive_axi_rvalid();
      if (i == 8) h_req_i = 3'b000;
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL axi_block cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      if (h_gnt_o[1] && first1 < 0) first1 = i;
      if (i == 3) begin
        total++;
        if (h_gnt_o !== 3'b100) begin
          bad++;
          $display("FAIL axi_block_gnt got=%b want=100", h_gnt_o);
        end
      end
      adv();
    end
    total++;
    if (first1 != 7) begin
      bad++;
      $display("FAIL axi_block_sram_gnt_cycle got=%0d want=7", first1);
    end
  endtask

  task automatic test_starve();
    int denied;
    bit got;
    denied = 0;
    got    = 0;
    set_host(1, rand_addr(0), 1'b0);
    set_host(2, rand_addr(0), 1'b0);
    h_req_i = 3'b110;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL starve cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      if (!got) begin
        if (h_gnt_o[2]) got = 1;
        else denied++;
      end
      adv();
      if (m_grant && m_w == 2) h_req_i[2] = 1'b0;
    end
    h_req_i = 3'b000;
    total++;
    if (!got || denied != STARVE_LIM) begin
      bad++;
      $display("FAIL starve_denied got=%0d granted=%0d want=%0d granted=1", denied, got, STARVE_LIM);
    end
    repeat (2) begin
      @(negedge clk_sys);
      model_eval();
      adv();
    end
  endtask

  task automatic test_unmapped();
    set_host(0, 32'h4000_0000, 1'b0);
    h_req_i = 3'b001;
    @(negedge clk_sys);
    model_eval();
    total++;
    if (h_gnt_o !== 3'b001 || s_req_o !== 3'b000) begin
      bad++;
      $display("FAIL unmapped_gnt got=%b/%b want=001/000", h_gnt_o, s_req_o);
    end
    adv();
    h_req_i = 3'b000;
    @(negedge clk_sys);
    model_eval();
    total++;
    if (h_rvalid_o !== 3'b001 || h_err_o !== 3'b001 || h_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL unmapped_rsp got=%b/%b/%h want=001/001/0", h_rvalid_o, h_err_o, h_rdata_o);
    end
    adv();
  endtask

  task automatic test_axi_outst();
    int ho [5];
    int order[$];
    int eh;
    s_gnt_i[2] = 1'b1;
    for (int k = 0; k < 5; k++) ho[k] = $urandom_range(0, 2);
    for (int k = 0; k < 4; k++) begin
      h_req_i = 3'b000;
      h_req_i[ho[k]] = 1'b1;
      set_host(ho[k], rand_addr(2), 1'b0);
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL axi_outst_issue%0d got=%h want=%h", k, obs_v(), exp_v());
      end
      order.push_back(ho[k]);
      adv();
    end
    h_req_i = 3'b000;
    h_req_i[ho[4]] = 1'b1;
    set_host(ho[4], rand_addr(2), 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      total++;
      if (i < 4 && (h_gnt_o !== 3'b000 || s_req_o !== 3'b000)) begin
        bad++;
        $display("FAIL axi_outst_full cyc%0d got=%b/%b want=000/000", i, h_gnt_o, s_req_o);
      end else if (i == 4 && h_gnt_o !== (3'b001 << ho[4])) begin
        bad++;
        $display("FAIL axi_outst_5th got=%b want=%b", h_gnt_o, 3'b001 << ho[4]);
      end
      if (i == 3) begin
        eh = order.pop_front();
        total++;
        if (h_rvalid_o !== (3'b001 << eh) || h_rdata_o !== rd[2]) begin
          bad++;
          $display("FAIL axi_outst_rsp0 got=%b/%h want=%b/%h", h_rvalid_o, h_rdata_o, 3'b001 << eh, rd[2]);
        end
      end
      adv();
    end
    order.push_back(ho[4]);
    h_req_i = 3'b000;
    for (int i = 0; i < 2; i++) begin
      drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      eh = order.pop_front();
      total++;
      if (h_rvalid_o !== (3'b001 << eh) || h_rdata_o !== rd[2] || obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL axi_outst_order%0d got=%b/%h want=%b/%h", i, h_rvalid_o, h_rdata_o, 3'b001 << eh, rd[2]);
      end
      adv();
    end
    rst_sys_n = 1'b0;
    q.delete();
    order.delete();
    mstarve = 0;
    for (int i = 0; i < 2; i++) begin
      drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== '0) begin
        bad++;
        $display("FAIL axi_outst_in_reset cyc%0d got=%h want=0", i, obs_v());
      end
      adv();
    end
    rst_sys_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      total++;
      if (h_rvalid_o !== 3'b000 || h_rdata_o !== 32'h0) begin
        bad++;
        $display("FAIL axi_outst_late_rvalid cyc%0d got=%b/%h want=000/0", i, h_rvalid_o, h_rdata_o);
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      for (int h = 0; h < 3; h++) begin
        if (!h_req_i[h] || (m_grant && m_w == h)) begin
          h_req_i[h] = ($urandom_range(0, 1) == 1);
          set_host(h, rand_addr($urandom_range(0, 3)), 1'($urandom));
        end
      end
      s_gnt_i[2] = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && q[0].dev == 2 && $urandom_range(0, 1) == 1) drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL random cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      adv();
    end
    h_req_i = 3'b000;
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      if (q[0].dev == 2) drive_axi_rvalid();
      @(negedge clk_sys);
      model_eval();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL random_drain cyc%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      adv();
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL random_drain_left got=%0d want=0", q.size());
    end
  endtask

  initial begin
    rst_sys_n  = 1'b0;
    h_req_i    = 3'b000;
    h_addr_i   = '0;
    h_we_i     = '0;
    h_be_i     = '0;
    h_wdata_i  = '0;
    s_gnt_i    = 3'b011;
    s_rvalid_i = 3'b000;
    rd[0] = $urandom; rd[1] = $urandom; rd[2] = $urandom;
    s_rdata_i  = {rd[2], rd[1], rd[0]};
    m_grant = 0; m_pop = 0; m_w = -1; m_d = 3;
    test_reset();
    test_sram_b2b();
    test_axi_block();
    test_starve();
    test_unmapped();
    test_axi_outst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
